// File: rtl/if_stage.sv
// Instruction-fetch stage: next-PC generation, inst SRAM read control and a
// one-entry hold buffer that keeps the fetched word stable while ID stalls.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_allowin,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  output logic        if_to_id_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  // PC value held in reset so the first increment lands on RESET_PC.
  localparam logic [31:0] PRE_RESET_PC = RESET_PC - 32'd4;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  logic        fs_allowin;
  logic [31:0] next_pc;

  // The slot may advance when empty, when ID takes it, or when a redirect
  // cancels it; the redirect target overrides sequential fetch.
  always_comb begin
    fs_allowin = !fs_valid_q || id_allowin || br_taken;
    next_pc    = br_taken ? br_target : (fs_pc_q + 32'd4);
  end

  // Next-state: advance on allowin, otherwise hold the slot and capture the
  // SRAM word on the first stall cycle, the only cycle it is guaranteed valid.
  always_comb begin
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (fs_allowin) begin
      fs_valid_d  = 1'b1;
      fs_pc_d     = next_pc;
      buf_valid_d = 1'b0;
    end else if (!buf_valid_q) begin
      inst_buf_d  = inst_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  // State registers; reset clears everything immediately, dropping any buffered word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= PRE_RESET_PC;
      buf_valid_q <= 1'b0;
      inst_buf_q  <= 32'h0;
    end else begin
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  // SRAM side: read-only port, address driven every cycle and qualified by en.
  always_comb begin
    inst_sram_en    = !rst && fs_allowin;
    inst_sram_we    = 4'b0000;
    inst_sram_addr  = next_pc;
    inst_sram_wdata = 32'h0;
  end

  // ID side: a redirect cancels the presented slot in the same cycle.
  always_comb begin
    if_to_id_valid = fs_valid_q && !br_taken;
    if_pc          = fs_pc_q;
    if_inst        = buf_valid_q ? inst_buf_q : inst_sram_rdata;
  end

endmodule
